// File: rtl/mergesort_sched.sv
// mergesort_sched: round-robin command scheduler for the shared MergeSort accelerator
module mergesort_sched #(
   parameter int ADDR_W  = 8,
   parameter int LEN_W   = 8,
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                clock_i,
   input  logic                reset_ni,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [2*ADDR_W-1:0] req_base_i,
   input  logic [2*LEN_W-1:0]  req_len_i,
   output logic                acc_start_o,
   output logic                acc_abort_o,
   output logic [ADDR_W-1:0]   acc_base_o,
   output logic [LEN_W-1:0]    acc_len_o,
   input  logic                acc_done_i,
   output logic                resp_valid_o,
   output logic                resp_id_o,
   output logic [1:0]          resp_status_o,
   output logic                stall_o,
   output logic                busy_o
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_LEN = 2'b01;
   localparam logic [1:0] ST_TO  = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic               id_q, id_d;
   logic [1:0]         status_q, status_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               grant;
   logic [LEN_W-1:0]   sel_len;
   logic               len_bad;
   logic               len_trivial;

   // port not granted last wins a tie; otherwise whichever port is valid
   assign grant       = (&req_valid_i) ? ~last_q : req_valid_i[1];
   assign sel_len     = grant ? req_len_i[LEN_W +: LEN_W] : req_len_i[0 +: LEN_W];
   assign len_bad     = 32'(sel_len) > MAX_LEN;
   assign len_trivial = sel_len <= LEN_W'(1);

   assign acc_base_o    = base_q;
   assign acc_len_o     = len_q;
   assign resp_id_o     = id_q;
   assign resp_status_o = status_q;
   assign busy_o        = state_q != IDLE;
   assign stall_o       = busy_o && !id_q;

   // state and job registers; reset drops any job in flight silently
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         status_q <= ST_OK;
         base_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         status_q <= status_d;
         base_q   <= base_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
      end
   end

   // next-state and pulse outputs; done beats timeout in the same WAIT cycle
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      status_d     = status_q;
      base_d       = base_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      req_ready_o  = 2'b00;
      acc_start_o  = 1'b0;
      acc_abort_o  = 1'b0;
      resp_valid_o = 1'b0;
      case (state_q)
         IDLE: if (|req_valid_i) begin
            req_ready_o = grant ? 2'b10 : 2'b01;
            last_d      = grant;
            id_d        = grant;
            base_d      = grant ? req_base_i[ADDR_W +: ADDR_W] : req_base_i[0 +: ADDR_W];
            len_d       = sel_len;
            status_d    = len_bad ? ST_LEN : ST_OK;
            state_d     = (len_bad || len_trivial) ? RESP : ISSUE;
         end
         ISSUE: begin
            acc_start_o = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT;
         end
         WAIT: begin
            cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
            if (acc_done_i) begin
               status_d = ST_OK;
               state_d  = RESP;
            end else if (cnt_q == CNT_LAST) begin
               acc_abort_o = 1'b1;
               status_d    = ST_TO;
               state_d     = RESP;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mergesort_sched.sv
// tb_mergesort_sched: directed plus randomized jobs checked against a transaction-level model
module tb_mergesort_sched;
   localparam int TO   = 8;
   localparam int MAXL = 16;

   logic        clock_i = 1'b0;
   logic        reset_ni;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [15:0] req_base_i;
   logic [15:0] req_len_i;
   logic        acc_start_o, acc_abort_o, acc_done_i;
   logic [7:0]  acc_base_o, acc_len_o;
   logic        resp_valid_o, resp_id_o, stall_o, busy_o;
   logic [1:0]  resp_status_o;

   int passed = 0;
   int total  = 0;
   int last   = 1;

   mergesort_sched #(.ADDR_W(8), .LEN_W(8), .MAX_LEN(MAXL), .TIMEOUT(TO)) dut (
      .clock_i(clock_i), .reset_ni(reset_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_base_i(req_base_i), .req_len_i(req_len_i),
      .acc_start_o(acc_start_o), .acc_abort_o(acc_abort_o),
      .acc_base_o(acc_base_o), .acc_len_o(acc_len_o), .acc_done_i(acc_done_i),
      .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_status_o(resp_status_o),
      .stall_o(stall_o), .busy_o(busy_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock_i);
      #2;
   endtask

   // response code from the job's length and the WAIT cycle (1-based) carrying done; 0 = never
   function automatic logic [1:0] exp_status(input int l, input int dk);
      if (l <= 1) return 2'd0;
      if (l > MAXL) return 2'd1;
      return (dk >= 1 && dk <= TO) ? 2'd0 : 2'd2;
   endfunction

   // one request on port p from IDLE through RESP back to IDLE
   task automatic job(input int p, input logic [7:0] b, input logic [7:0] l, input int dk);
      logic [1:0] st;
      st = exp_status(int'(l), dk);
      req_base_i = 16'($urandom);
      req_len_i  = 16'($urandom);
      req_base_i[p*8 +: 8] = b;
      req_len_i[p*8 +: 8]  = l;
      req_valid_i = 2'(1 << p);
      #1;
      chk("ready_idle", 32'(req_ready_o), 32'(1 << p));
      chk("busy_idle", busy_o, 0);
      tick();
      req_valid_i = 2'b00;
      last = p;
      if (l > 1 && l <= MAXL) begin
         #1;
         chk("acc_start", acc_start_o, 1);
         chk("acc_base", acc_base_o, b);
         chk("acc_len", acc_len_o, l);
         chk("stall_issue", stall_o, p == 0);
         acc_done_i = 1'($urandom);
         for (int k = 1; k <= TO; k++) begin
            tick();
            acc_done_i = (k == dk);
            #1;
            chk("abort", acc_abort_o, k == TO && k != dk);
            chk("start_wait", acc_start_o, 0);
            chk("stall_wait", stall_o, p == 0);
            if (k == dk) break;
         end
         tick();
      end
      acc_done_i  = 1'($urandom);
      req_valid_i = 2'b11;
      #1;
      chk("resp_valid", resp_valid_o, 1);
      chk("resp_id", resp_id_o, p);
      chk("resp_status", resp_status_o, st);
      chk("ready_resp", req_ready_o, 0);
      chk("acc_start_resp", acc_start_o, 0);
      chk("stall_resp", stall_o, p == 0);
      chk("base_hold", acc_base_o, b);
      req_valid_i = 2'b00;
      tick();
      acc_done_i = 1'b0;
      #1;
      chk("resp_gone", resp_valid_o, 0);
      chk("busy_done", busy_o, 0);
      chk("stall_done", stall_o, 0);
   endtask

   initial begin
      int g;
      logic [7:0] lens [2];
      reset_ni    = 1'b0;
      req_valid_i = 2'b00;
      req_base_i  = '0;
      req_len_i   = '0;
      acc_done_i  = 1'b0;
      #3;
      chk("rst_start", acc_start_o, 0);
      chk("rst_abort", acc_abort_o, 0);
      chk("rst_resp", resp_valid_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_id", resp_id_o, 0);
      chk("rst_status", resp_status_o, 0);
      chk("rst_base", acc_base_o, 0);
      chk("rst_len", acc_len_o, 0);
      req_valid_i = 2'b01;
      #1;
      chk("rst_ready", req_ready_o, 2'b01);
      req_valid_i = 2'b00;
      tick();
      tick();
      reset_ni = 1'b1;
      // both ports held valid: grants alternate, port 0 first
      lens[0] = 8'd1;
      lens[1] = 8'd17;
      for (int r = 0; r < 4; r++) begin
         req_len_i   = {lens[1], lens[0]};
         req_base_i  = 16'($urandom);
         req_valid_i = 2'b11;
         g = (last == 1) ? 0 : 1;
         #1;
         chk("tie_ready", 32'(req_ready_o), 32'(1 << g));
         tick();
         last = g;
         #1;
         chk("tie_id", resp_id_o, g);
         chk("tie_status", resp_status_o, exp_status(int'(lens[g]), 0));
         chk("tie_ready_resp", req_ready_o, 0);
         tick();
      end
      req_valid_i = 2'b00;
      // directed jobs
      job(0, 8'h10, 8'd8, 5);
      job(1, 8'h21, 8'd1, 0);
      job(0, 8'h22, 8'd17, 0);
      job(1, 8'h23, 8'd0, 0);
      job(0, 8'h40, 8'd12, 0);
      job(1, 8'h41, 8'd2, 1);
      job(0, 8'h50, 8'd16, TO);
      job(1, 8'h51, 8'd9, TO + 1);
      // reset during WAIT: no response, no abort
      req_base_i  = 16'h0033;
      req_len_i   = 16'h0008;
      req_valid_i = 2'b01;
      tick();
      req_valid_i = 2'b00;
      tick();
      tick();
      #1;
      chk("busy_wait", busy_o, 1);
      reset_ni = 1'b0;
      #1;
      chk("mid_busy", busy_o, 0);
      chk("mid_stall", stall_o, 0);
      chk("mid_base", acc_base_o, 0);
      chk("mid_len", acc_len_o, 0);
      chk("mid_abort", acc_abort_o, 0);
      chk("mid_resp", resp_valid_o, 0);
      chk("mid_status", resp_status_o, 0);
      tick();
      #1;
      chk("mid_resp2", resp_valid_o, 0);
      reset_ni = 1'b1;
      last = 1;
      tick();
      job(1, 8'h77, 8'd5, 3);
      // randomized jobs
      for (int n = 0; n < 40; n++)
         job(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 20)),
             int'($urandom_range(1, TO + 2)));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mergesort_sched.md
# mergesort_sched

Command scheduler for the single shared MergeSort accelerator. It takes sort requests from two requesters: port 0 is the core pipeline's custom sort opcode, port 1 is the debug/DMA loader. It grants one request at a time with round-robin arbitration, drives the accelerator's start, base and length, and supervises completion with a timeout. It then returns a status response to the winning requester and holds a stall line to the core pipeline while a port-0 job is outstanding.

## Interface
- ADDR_W, 8: width of the data-memory base address.
- LEN_W, 8: width of the element-count field.
- MAX_LEN, 16: largest legal element count.
- TIMEOUT, 1024: cycles in WAIT before the job is declared hung. Must be ≥2.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port accept; one-hot or zero.
- req_base  in  2*ADDR_W  per-port base address; port i occupies [i*ADDR_W +: ADDR_W].
- req_len  in  2*LEN_W  per-port element count, same packing as req_base.
- acc_start  out  1  one-cycle start pulse to the accelerator.
- acc_abort  out  1  one-cycle abort pulse, issued on timeout.
- acc_base  out  ADDR_W  latched base; stable from ISSUE until return to IDLE.
- acc_len  out  LEN_W  latched length; stable from ISSUE until return to IDLE.
- acc_done  in  1  accelerator completion; level or pulse.
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  1  port that owns the response.
- resp_status  out  2  response code: 00 OK, 01 ERR_LEN, 10 TIMEOUT.
- stall  out  1  high while a port-0 job is in ISSUE, WAIT or RESP.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant one port.
  - If both are valid, grant the port that was not granted last (last_grant register).
  - req_ready[g] is asserted combinationally in IDLE only, and the transfer happens on that edge.
  - The transfer latches base, len and id, and updates last_grant to g.
- Length check at accept time:
  - len 0 or 1: go directly to RESP with status OK. The accelerator is not started.
  - len > MAX_LEN: go to RESP with status ERR_LEN. The accelerator is not started.
  - Otherwise go to ISSUE.
- ISSUE: acc_start=1 for exactly this cycle. Clear the timeout counter, then go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - acc_done=1 → RESP with status OK.
  - Otherwise, counter reaching TIMEOUT-1 → pulse acc_abort and go to RESP with status TIMEOUT.
  - If done and timeout occur in the same cycle, done wins (status OK, no abort).
- RESP: resp_valid=1 with resp_id and resp_status, then go to IDLE.
  - No new request is accepted in this cycle.
- acc_done is ignored outside WAIT. A done arriving during IDLE, ISSUE or RESP is dropped.
- A requester that deasserts req_valid before it sees req_ready is simply not served. No state is kept for it.
- The counter is TIMEOUT-sized, with width clog2(TIMEOUT). It saturates and never wraps.

## Timing
- Reset (reset=0), asynchronous, forces:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), counter=0.
  - req_ready=0 is not forced: it follows IDLE and req_valid combinationally, so it can be 1 during reset.
  - All other outputs are 0: acc_start, acc_abort, resp_valid, stall, busy, resp_id, resp_status, acc_base, acc_len.
- Reset asserted mid-job: return to IDLE immediately. No response and no abort are issued; the accelerator's own reset covers it.
- Legal job, accepted at edge T:
  - ISSUE during cycle T+1, so acc_start is high in T+1.
  - WAIT from T+2.
  - acc_done sampled high at edge T+2+k gives resp_valid during cycle T+3+k.
  - IDLE at T+4+k; next accept no earlier than edge T+4+k.
- Trivial or illegal length accepted at T: resp_valid during T+1, IDLE at T+2.
- Timeout: acc_abort and the RESP transition happen on the TIMEOUT-th WAIT cycle. resp_valid follows one cycle later.
- stall rises in the cycle after a port-0 accept and falls when state returns to IDLE.

## Test plan
- Single port-0 request, base=0x10, len=8, acc_done raised 5 cycles after acc_start:
  - acc_start is one cycle, with acc_base=0x10 and acc_len=8.
  - resp_valid with id=0, status=00.
  - stall high from ISSUE through RESP.
- Both ports valid on the first cycle after reset, held:
  - Port 0 is served first, then port 1.
  - Both then valid again: port 0 wins (last_grant=1).
- len=1, then len=17 (MAX_LEN=16):
  - No acc_start in either case.
  - Responses are status 00 and then 01, each one cycle after accept.
- acc_done never asserted, TIMEOUT=8:
  - acc_abort pulses on the 8th WAIT cycle.
  - resp_status=10 follows.
  - Scheduler then accepts a new request.
- acc_done asserted on the same cycle the counter hits TIMEOUT-1: status 00 and no acc_abort.
- reset driven low during WAIT:
  - All outputs go to reset values immediately.
  - No resp_valid.
  - After release, a fresh port-1 request completes normally.
